uart_apb_master: RTL
====================

// Module: uart_apb_master
// PURPOSE
//  APB3 initiator that drives the CoreUARTapb register file from a simple one-command-at-a-time request port.
//  Optional status polling: before the main access, re-reads STATUS until (PRDATA & CMD_MASK) != 0.
//  Sits between a local controller/sequencer and the UART APB slave, on the same PCLK domain.
// PARAMETERS
//  STATUS_ADDR   5'h10  PADDR used for poll reads (UART status register)
//  POLL_TIMEOUT  1024   max poll reads per command; 0 = unlimited
// PORTS
//  PCLK        in   1  clock; all logic on rising edge
//  PRESET      in   1  synchronous, active-high reset
//  CMD_VALID   in   1  command request
//  CMD_READY   out  1  command accepted when CMD_VALID & CMD_READY
//  CMD_WRITE   in   1  1 = write, 0 = read
//  CMD_ADDR    in   5  target register offset
//  CMD_WDATA   in   8  write data
//  CMD_POLL    in   1  poll STATUS_ADDR before the main access
//  CMD_MASK    in   8  poll bit mask (for example 8'h01 = TXRDY, 8'h02 = RXRDY)
//  RSP_VALID   out  1  one-cycle pulse: command complete
//  RSP_RDATA   out  8  read data (0 for writes); valid with RSP_VALID
//  RSP_ERR     out  1  PSLVERR seen on the completing transfer; valid with RSP_VALID
//  RSP_TIMEOUT out  1  poll limit reached, main access skipped; valid with RSP_VALID
//  PADDR       out  5  APB address
//  PSEL        out  1  APB select
//  PENABLE     out  1  APB enable
//  PWRITE      out  1  APB direction
//  PWDATA      out  8  APB write data
//  PRDATA      in   8  APB read data
//  PREADY      in   1  APB ready (wait states honoured even though the slave ties it to 1)
//  PSLVERR     in   1  APB error
// BEHAVIOUR
//  - Reset while PRESET=1 at an edge:
//    - state=IDLE, poll count=0.
//    - All APB outputs and RSP_* outputs go to 0.
//    - CMD_READY = (state==IDLE) & !PRESET.
//  - Reset mid-transfer: abort. PSEL/PENABLE are 0 after the edge and no RSP_VALID is issued.
//  - States: IDLE, P_SETUP, P_ACCESS, SETUP, ACCESS, RESP.
//  - IDLE:
//    - On accept, latch all CMD_* fields.
//    - Next state is P_SETUP if CMD_POLL & (CMD_MASK != 0), else SETUP.
//    - A mask of 0 disables polling.
//  - P_SETUP: PSEL=1, PENABLE=0, PWRITE=0, PADDR=STATUS_ADDR, PWDATA=0.
//  - P_ACCESS: PENABLE=1. Stay here while !PREADY. When PREADY=1, check in this order:
//    - PSLVERR -> RESP with ERR=1.
//    - (PRDATA & mask) != 0 -> SETUP.
//    - count == POLL_TIMEOUT-1 (POLL_TIMEOUT != 0) -> RESP with TIMEOUT=1.
//    - Otherwise count++ and go to P_SETUP (back-to-back transfers, PSEL stays 1).
//  - Poll count is cleared on accept. It counts completed poll reads, not wait cycles.
//  - SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE from the latched command.
//    - PWDATA = latched data for writes, 0 for reads.
//  - ACCESS: PENABLE=1, all APB outputs held stable. Stay here while !PREADY.
//    - When PREADY=1: capture PRDATA (reads only) and PSLVERR, then go to RESP.
//  - RESP: RSP_VALID=1 for exactly 1 cycle, PSEL=0, then IDLE.
//    - RSP_* fields hold their values until the next RESP.
//  - APB outputs are registered (driven from state flops); no combinational path from PRDATA/PREADY to APB outputs.
//  - Latency, no poll, PREADY=1: accept edge 0; SETUP cycle 1; ACCESS cycle 2; RSP_VALID cycle 3; CMD_READY cycle 4.
//  - Each poll round with PREADY=1 adds 2 cycles.
//  - Reads rely on the slave presenting PRDATA during ACCESS (the slave latches it in SETUP). Sample only at ACCESS & PREADY.
//  - CMD_VALID while !CMD_READY is ignored; the requester holds it.
//  - Count width = $clog2(POLL_TIMEOUT+1), minimum 1. Unlimited mode never sets TIMEOUT.
// STRUCTURE
//  - Shared package uart_apb_pkg:
//    - Register offsets: TXDATA 5'h00, RXDATA 5'h04, CTRL1 5'h08, CTRL2 5'h0C, STATUS 5'h10, CTRL3 5'h14.
//    - Status bit indices: TXRDY 0, RXRDY 1, PARITY_ERR 2, OVERFLOW 3, FRAMING_ERR 4.
//    - The FSM state encoding.
//  - Single flat module; no sub-module is warranted. FSM, command latch and poll counter are local.
// TESTING
//  1. Write CTRL1 8'h1A, no poll, PREADY=1 -> PSEL cycles 1-2, PENABLE cycle 2 only, PADDR=5'h08, PWDATA=8'h1A;
//     RSP_VALID cycle 3, RSP_ERR=0.
//  2. Read RXDATA with poll mask 8'h02; status reads return 8'h01, 8'h01, then 8'h03; RXDATA returns 8'h5A
//     -> 3 poll reads, then 1 read of 5'h04; RSP_RDATA=8'h5A.
//  3. POLL_TIMEOUT=4, status always 8'h00 -> exactly 4 poll reads; RSP_TIMEOUT=1; no access to CMD_ADDR.
//  4. PREADY held low 3 cycles in ACCESS -> PADDR/PWRITE/PWDATA stable; RSP_VALID 1 cycle after PREADY rises.
//  5. PSLVERR=1 on a poll read -> RSP_ERR=1, main access skipped; PSLVERR=1 on main write -> RSP_ERR=1.
//  6. PRESET pulsed during ACCESS -> PSEL=PENABLE=0 next cycle, no RSP_VALID; CMD_READY=1 the cycle after PRESET falls.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the CoreUARTapb APB master: register map, status bits
// and the master FSM state encoding.
package uart_apb_pkg;

    localparam logic [4:0] REG_TXDATA = 5'h00;
    localparam logic [4:0] REG_RXDATA = 5'h04;
    localparam logic [4:0] REG_CTRL1  = 5'h08;
    localparam logic [4:0] REG_CTRL2  = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;
    localparam logic [4:0] REG_CTRL3  = 5'h14;

    localparam int BIT_TXRDY       = 0;
    localparam int BIT_RXRDY       = 1;
    localparam int BIT_PARITY_ERR  = 2;
    localparam int BIT_OVERFLOW    = 3;
    localparam int BIT_FRAMING_ERR = 4;

    // Poll phase (S_P_*) and main phase (S_SETUP/S_ACCESS) each form one APB transfer.
    typedef enum logic [2:0] {
        S_IDLE,
        S_P_SETUP,
        S_P_ACCESS,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

endpackage

// File: rtl/uart_apb_master.sv
// APB3 initiator for the CoreUARTapb register file: one command at a time, with
// optional STATUS polling before the main access.
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter logic [4:0]  STATUS_ADDR  = REG_STATUS,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_WRITE,
    input  logic [4:0] CMD_ADDR,
    input  logic [7:0] CMD_WDATA,
    input  logic       CMD_POLL,
    input  logic [7:0] CMD_MASK,
    output logic       RSP_VALID,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_ERR,
    output logic       RSP_TIMEOUT,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    localparam int             CNT_W        = (POLL_TIMEOUT == 0) ? 1 : $clog2(POLL_TIMEOUT + 1);
    localparam bit             POLL_LIMITED = (POLL_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(POLL_TIMEOUT - 1);

    state_e           state_q,   state_d;
    logic             write_q,   write_d;
    logic [4:0]       addr_q,    addr_d;
    logic [7:0]       wdata_q,   wdata_d;
    logic [7:0]       mask_q,    mask_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [7:0]       rdata_q,   rdata_d;
    logic             err_q,     err_d;
    logic             timeout_q, timeout_d;

    logic cmd_accept;
    logic poll_phase;
    logic main_phase;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_accept = CMD_VALID && CMD_READY;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can infer a latch.
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    write_d = CMD_WRITE;
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    mask_d  = CMD_MASK;
                    cnt_d   = '0;
                    state_d = (CMD_POLL && (CMD_MASK != '0)) ? S_P_SETUP : S_SETUP;
                end
            end
            S_P_SETUP: state_d = S_P_ACCESS;
            S_P_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        rdata_d   = '0;
                        err_d     = 1'b1;
                        timeout_d = 1'b0;
                        state_d   = S_RESP;
                    end else if ((PRDATA & mask_q) != '0) begin
                        state_d = S_SETUP;
                    end else if (POLL_LIMITED && (cnt_q == CNT_LAST)) begin
                        rdata_d   = '0;
                        err_d     = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_P_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    rdata_d   = write_q ? '0 : PRDATA;
                    err_d     = PSLVERR;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // APB and response outputs decode flops only; PRDATA/PREADY never reach them combinationally.
    assign poll_phase = (state_q == S_P_SETUP) || (state_q == S_P_ACCESS);
    assign main_phase = (state_q == S_SETUP) || (state_q == S_ACCESS);

    assign CMD_READY   = (state_q == S_IDLE) && !PRESET;
    assign PSEL        = poll_phase || main_phase;
    assign PENABLE     = (state_q == S_P_ACCESS) || (state_q == S_ACCESS);
    assign PADDR       = poll_phase ? STATUS_ADDR : (main_phase ? addr_q : '0);
    assign PWRITE      = main_phase && write_q;
    assign PWDATA      = (main_phase && write_q) ? wdata_q : '0;
    assign RSP_VALID   = (state_q == S_RESP);
    assign RSP_RDATA   = rdata_q;
    assign RSP_ERR     = err_q;
    assign RSP_TIMEOUT = timeout_q;

endmodule
